strobe_sequencer: RTL and testbench
===================================

# strobe_sequencer

Round-robin scheduler for the multi-polarization stroboscopic illumination channels. It steps through the enabled channels once per frame, driving one channel's strobe output high for that channel's programmed on-time and inserting a dead-time gap between channels. It runs from the board switches (run enable plus channel mask) and a small configuration write port. It sits between the switch/config logic and the LED driver pins, and owns sequencing of the shared illumination path.

## Interface
- NCH, 4: number of illumination channels (2..8)
- TW, 16: width of on-time and gap counters, in SCLOCK cycles
- SCLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- SW17  in  1  run enable, raw switch, asynchronous to SCLOCK
- SW3t0  in  NCH  channel enable mask, raw switches, asynchronous to SCLOCK
- cfg_we  in  1  config write strobe, one cycle per write
- cfg_addr  in  $clog2(NCH+1)  0..NCH-1 selects a channel on-time; NCH selects gap
- cfg_data  in  TW  write data
- PWM  out  NCH  strobe outputs, at most one bit high
- active_ch  out  $clog2(NCH)  index of the channel currently in ON or OFF
- frame_start  out  1  one-cycle pulse in LOAD
- frame_done  out  1  one-cycle pulse on the last cycle of the last channel's gap
- busy  out  1  high in every state except IDLE

## Operation
- Synchronizers: SW17 and SW3t0 each pass through a 2-flop synchronizer before use. Reset value of the synchronizer flops is 0.
- Registers:
  - ontime[NCH] and gap are written by cfg_* at any time.
  - At LOAD they are copied into shadow registers, together with the synchronized mask.
  - The frame uses only the shadow values, so mid-frame writes take effect at the next frame.
  - Reset values: ontime = 0, gap = 1.
- Effective mask: eff[i] = mask_s[i] AND (ontime_sh[i] != 0).
- States: IDLE, LOAD, ON, OFF.
  - IDLE -> LOAD when SW17_s = 1.
  - LOAD: latch shadows and pulse frame_start.
    - eff = 0 -> IDLE.
    - Otherwise -> ON, with ch = lowest set bit of eff and cnt = ontime_sh[ch].
  - ON: PWM[ch] = 1 and cnt decrements. At cnt = 1 -> OFF, with cnt = max(gap_sh, 1).
  - OFF: PWM = 0 and cnt decrements. At cnt = 1:
    - If a higher set bit of eff exists: -> ON at that channel.
    - Otherwise: pulse frame_done, then -> LOAD if SW17_s = 1, else -> IDLE.
  - SW17_s = 0 in ON: -> OFF immediately (gap still applied), then -> IDLE after the gap. frame_done is not pulsed.
  - SW17_s = 0 in OFF: -> IDLE after the gap.
- Outputs are registered.
  - PWM is a decode of state = ON and ch, so it is glitch-free and break-before-make.
  - Reset values: PWM = 0, active_ch = 0, frame_start = 0, frame_done = 0, busy = 0, state = IDLE, cnt = 0.
- Asserting RESET at any time forces all outputs to their reset values immediately, with no gap.

## Timing
- Startup latency: SW17 high and stable before edge E0 -> SW17_s high after E1 -> LOAD after E2 (frame_start high) -> PWM high after E3.
- A channel with ontime = N holds its PWM bit high for exactly N cycles.
- Gap G yields exactly max(G, 1) cycles with PWM = 0 between channels, and after the last channel.
- Frame length = 1 (LOAD) + sum over enabled channels of (ontime + max(gap, 1)).
- Back-to-back frames: LOAD follows the final OFF cycle directly, with no IDLE cycle.
- Counters are TW bits, unsigned. ontime = 2^TW - 1 is the maximum, and no wrap can occur.
- A cfg write in the same cycle as LOAD is not captured into the shadows; it applies to the following frame.
- Mask changes are visible only at LOAD.

## Structure
- Shared package strobe_pkg holds:
  - the state enum (IDLE, LOAD, ON, OFF);
  - the cfg address constant GAP_ADDR = NCH;
  - the default reset values.
- One sub-module: sync2, a 2-flop synchronizer parameterized by width and instantiated for SW17 and SW3t0.
- Next-channel selection is a combinational priority encoder inside strobe_sequencer; it is not a separate module.

## Test plan
- Reset and startup: RESET low, then high; SW17 = 0 -> all outputs 0, busy = 0 indefinitely. Raise SW17 -> frame_start on the 3rd edge, first PWM on the 4th.
- Full frame: NCH = 4, ontime = {3, 5, 2, 4}, gap = 2, mask = 1111 -> PWM[0..3] high for 3/5/2/4 cycles with 2-cycle gaps. frame_done pulses once; frame length = 23 cycles; the next frame_start follows frame_done immediately.
- Skips: mask = 1010 and ontime[3] = 0 -> only channel 1 strobes. Mask = 0000 -> LOAD returns to IDLE, with PWM never high.
- Gap = 0 -> exactly 1 dead cycle between channels. PWM never has two bits high (checked every cycle).
- Mid-frame changes:
  - Writing ontime[1] = 9 during channel 0 leaves the current frame at 5 cycles; the next frame uses 9.
  - Dropping SW17 during ON cuts the pulse, applies the gap, returns to IDLE, and frame_done stays 0.
- Reset mid-ON: assert RESET asynchronously -> PWM goes to 0 without waiting for a clock edge, and the state returns to IDLE.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared types and constants for the strobe sequencer.
package strobe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StOn,
    StOff
  } strobe_state_e;

  // Default build configuration.
  localparam int unsigned NchDefault = 4;
  localparam int unsigned TwDefault  = 16;

  // The gap register sits one address past the last channel on-time register.
  localparam int unsigned GAP_ADDR = NchDefault;

  // Power-up values of the programmable timing registers.
  localparam int unsigned RstOntime = 0;
  localparam int unsigned RstGap    = 1;

  // Gap register address for an arbitrary channel count.
  function automatic int unsigned gap_addr(input int unsigned nch);
    return nch;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow, asynchronous level inputs (switches).
module sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture; the first stage may go metastable, the second is used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/strobe_sequencer.sv
// Round-robin strobe sequencer: one enabled channel at a time, each for its
// programmed on-time, separated by a dead-time gap, once per frame.
module strobe_sequencer
  import strobe_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  parameter int unsigned TW  = TwDefault,
  localparam int unsigned AW = $clog2(NCH + 1),
  localparam int unsigned CW = $clog2(NCH)
) (
  input  logic           SCLOCK,
  input  logic           RESET,
  input  logic           SW17,
  input  logic [NCH-1:0] SW3t0,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [TW-1:0]  cfg_data,
  output logic [NCH-1:0] PWM,
  output logic [CW-1:0]  active_ch,
  output logic           frame_start,
  output logic           frame_done,
  output logic           busy
);

  localparam logic [AW-1:0] GapAddr = AW'(gap_addr(NCH));

  logic           run_s;
  logic [NCH-1:0] mask_s;

  sync2 #(
    .Width(1)
  ) u_sync_run (
    .clk_i (SCLOCK),
    .rst_ni(RESET),
    .d_i   (SW17),
    .q_o   (run_s)
  );

  sync2 #(
    .Width(NCH)
  ) u_sync_mask (
    .clk_i (SCLOCK),
    .rst_ni(RESET),
    .d_i   (SW3t0),
    .q_o   (mask_s)
  );

  logic [TW-1:0]  ontime_q    [NCH];
  logic [TW-1:0]  gap_q;
  logic [TW-1:0]  ontime_sh_q [NCH];
  logic [TW-1:0]  gap_sh_q;
  logic [NCH-1:0] eff_sh_q;
  logic [NCH-1:0] eff_live;
  logic [TW-1:0]  gap_eff;

  strobe_state_e  state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           abort_q, abort_d;
  logic           done_d;

  logic [NCH-1:0] pwm_q;
  logic           frame_start_q;
  logic           frame_done_q;
  logic           busy_q;

  logic           first_vld;
  logic [CW-1:0]  first_ch;
  logic           next_vld;
  logic [CW-1:0]  next_ch;

  // Live configuration registers, writable at any time.
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NCH; i++) ontime_q[i] <= TW'(RstOntime);
      gap_q <= TW'(RstGap);
    end else if (cfg_we) begin
      if (cfg_addr == GapAddr) gap_q <= cfg_data;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_addr == AW'(i)) ontime_q[i] <= cfg_data;
      end
    end
  end

  // Zero on-time disables a channel even if its mask switch is on.
  always_comb begin
    eff_live = '0;
    for (int i = 0; i < NCH; i++) eff_live[i] = mask_s[i] && (ontime_q[i] != '0);
  end

  // Snapshot taken on the edge leaving LOAD, so a write during LOAD misses it.
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NCH; i++) ontime_sh_q[i] <= TW'(RstOntime);
      gap_sh_q <= TW'(RstGap);
      eff_sh_q <= '0;
    end else if (state_q == StLoad) begin
      for (int i = 0; i < NCH; i++) ontime_sh_q[i] <= ontime_q[i];
      gap_sh_q <= gap_q;
      eff_sh_q <= eff_live;
    end
  end

  assign gap_eff = (gap_sh_q == '0) ? TW'(1) : gap_sh_q;

  // Priority encoders: first channel of a new frame, next channel above ch_q.
  always_comb begin
    first_vld = 1'b0;
    first_ch  = '0;
    next_vld  = 1'b0;
    next_ch   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eff_live[i]) begin
        first_vld = 1'b1;
        first_ch  = CW'(i);
      end
      if (eff_sh_q[i] && (i > int'(ch_q))) begin
        next_vld = 1'b1;
        next_ch  = CW'(i);
      end
    end
  end

  // Next-state logic; abort_q remembers a run-switch drop that ends the frame early.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle: begin
        if (run_s) state_d = StLoad;
      end
      StLoad: begin
        abort_d = 1'b0;
        if (first_vld) begin
          state_d = StOn;
          ch_d    = first_ch;
          cnt_d   = ontime_q[first_ch];
        end else begin
          state_d = StIdle;
        end
      end
      StOn: begin
        if (!run_s || (cnt_q == TW'(1))) begin
          state_d = StOff;
          cnt_d   = gap_eff;
          abort_d = abort_q | !run_s;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      StOff: begin
        if (!run_s && next_vld) abort_d = 1'b1;
        if (cnt_q == TW'(1)) begin
          if (next_vld && !abort_d) begin
            state_d = StOn;
            ch_d    = next_ch;
            cnt_d   = ontime_sh_q[next_ch];
          end else if (!next_vld && !abort_q && run_s) begin
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // frame_done marks the final gap cycle of a frame that was not cut short.
  assign done_d = (state_d == StOff) && (cnt_d == TW'(1)) && !abort_d && !next_vld;

  // State, counters and registered outputs, all decoded from next state.
  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= StIdle;
      ch_q          <= '0;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      cnt_q         <= cnt_d;
      abort_q       <= abort_d;
      pwm_q         <= (state_d == StOn) ? (NCH'(1) << ch_d) : '0;
      frame_start_q <= (state_d == StLoad);
      frame_done_q  <= done_d;
      busy_q        <= (state_d != StIdle);
    end
  end

  assign PWM         = pwm_q;
  assign active_ch   = ch_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Self-checking bench for strobe_sequencer with a frame-level reference model.
module tb_strobe_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned TW  = 16;
  localparam int unsigned AW  = $clog2(NCH + 1);
  localparam int unsigned CW  = $clog2(NCH);

  logic           SCLOCK = 1'b0;
  logic           RESET  = 1'b1;
  logic           SW17   = 1'b0;
  logic [NCH-1:0] SW3t0  = '0;
  logic           cfg_we = 1'b0;
  logic [AW-1:0]  cfg_addr = '0;
  logic [TW-1:0]  cfg_data = '0;
  logic [NCH-1:0] PWM;
  logic [CW-1:0]  active_ch;
  logic           frame_start;
  logic           frame_done;
  logic           busy;

  strobe_sequencer #(
    .NCH(NCH),
    .TW (TW)
  ) dut (
    .SCLOCK     (SCLOCK),
    .RESET      (RESET),
    .SW17       (SW17),
    .SW3t0      (SW3t0),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .PWM        (PWM),
    .active_ch  (active_ch),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 SCLOCK = ~SCLOCK;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
    end
  endtask

  // One expected output cycle. fin: 0 mid-frame, 1 normal frame end, 2 cut-short end.
  typedef struct {
    logic [NCH-1:0] pwm;
    int             ch;
    bit             start;
    bit             done;
    bit             busy;
    bit             onoff;
    int             fin;
    bit             gap_end;
  } ent_t;

  ent_t           q[$];
  ent_t           cur;
  int             m_ontime[NCH];
  int             m_gap;
  int             m_fgap;
  bit             s1, s2;
  logic [NCH-1:0] m1, m2;

  int             fd_count, fs_count, fd_cycle;
  logic [NCH-1:0] pwm_or;

  function automatic ent_t mk_ent(input logic [NCH-1:0] p, input int c, input bit st, input bit dn,
                                  input bit bs, input bit oo, input int fn, input bit ge);
    ent_t e;
    e.pwm = p; e.ch = c; e.start = st; e.done = dn;
    e.busy = bs; e.onoff = oo; e.fin = fn; e.gap_end = ge;
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    cur = mk_ent('0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NCH; i++) m_ontime[i] = 0;
    m_gap  = 1;
    m_fgap = 1;
    s1 = 0; s2 = 0; m1 = '0; m2 = '0;
  endtask

  // Expand one frame into its per-cycle waveform from the captured settings.
  task automatic build_frame(input logic [NCH-1:0] msk);
    int             last;
    logic [NCH-1:0] one;
    one    = 1;
    last   = -1;
    m_fgap = (m_gap == 0) ? 1 : m_gap;
    for (int i = 0; i < NCH; i++) if (msk[i] && m_ontime[i] != 0) last = i;
    for (int i = 0; i < NCH; i++) begin
      if (msk[i] && m_ontime[i] != 0) begin
        for (int k = 0; k < m_ontime[i]; k++) q.push_back(mk_ent(one << i, i, 0, 0, 1, 1, 0, 0));
        for (int k = 0; k < m_fgap; k++) begin
          bit e;
          e = (k == m_fgap - 1);
          q.push_back(mk_ent('0, i, 0, e && (i == last), 1, 1, (e && (i == last)) ? 1 : 0, e));
        end
      end
    end
  endtask

  task automatic model_step();
    bit             sw_old;
    logic [NCH-1:0] msk_old;
    bit             pending;
    int             idx;
    ent_t           e;
    sw_old  = s2;
    msk_old = m2;
    if (cur.onoff && !sw_old) begin
      if (cur.pwm != '0) begin
        // Pulse cut: just this channel's gap remains, then idle.
        q.delete();
        for (int k = 0; k < m_fgap; k++)
          q.push_back(mk_ent('0, cur.ch, 0, 0, 1, 1, (k == m_fgap - 1) ? 2 : 0, k == m_fgap - 1));
      end else begin
        pending = 0;
        foreach (q[k]) if (q[k].pwm != '0) pending = 1;
        if (pending) begin
          if (cur.gap_end) begin
            q.delete();
            cur.fin = 2;
          end else begin
            idx = 0;
            for (int k = 0; k < q.size(); k++) begin
              if (q[k].gap_end) begin
                idx = k;
                break;
              end
            end
            while (q.size() > idx + 1) void'(q.pop_back());
            e = q[idx];
            e.fin = 2;
            q[idx] = e;
          end
        end
      end
    end
    if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur.start) begin
      build_frame(msk_old);
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk_ent('0, 0, 0, 0, 0, 0, 0, 0);
    end else if (sw_old && (!cur.busy || cur.fin == 1)) begin
      cur = mk_ent('0, 0, 1, 0, 1, 0, 0, 0);
    end else begin
      cur = mk_ent('0, 0, 0, 0, 0, 0, 0, 0);
    end
    if (cfg_we) begin
      if (int'(cfg_addr) == NCH) m_gap = int'(cfg_data);
      else if (int'(cfg_addr) < NCH) m_ontime[cfg_addr] = int'(cfg_data);
    end
    s2 = s1; s1 = SW17; m2 = m1; m1 = SW3t0;
  endtask

  task automatic compare();
    check_eq("pwm", 32'(PWM), 32'(cur.pwm));
    check_eq("busy", 32'(busy), 32'(cur.busy));
    check_eq("frame_start", 32'(frame_start), 32'(cur.start));
    check_eq("frame_done", 32'(frame_done), 32'(cur.done));
    if (cur.onoff) check_eq("active_ch", 32'(active_ch), cur.ch);
    check_eq("pwm_onehot", 32'($countones(PWM) <= 1), 1);
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cycle = cycle;
    end
    if (frame_start === 1'b1) fs_count++;
    pwm_or |= PWM;
  endtask

  task automatic tick();
    @(posedge SCLOCK);
    if (!RESET) model_reset();
    else model_step();
    cycle++;
    @(negedge SCLOCK);
    compare();
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = TW'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_fs(output int cyc);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (frame_start !== 1'b1 && t < 500);
    check_eq("wait_frame_start", 32'(frame_start), 1);
    cyc = cycle;
  endtask

  task automatic wait_pwm(input int ch);
    int t;
    t = 0;
    while (PWM[ch] !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    check_eq("wait_pwm", 32'(PWM[ch]), 1);
  endtask

  task automatic measure_pulse(input int ch, output int len);
    int t;
    t   = 0;
    len = 0;
    while (PWM[ch] !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    while (PWM[ch] === 1'b1 && len < 1000) begin
      len++;
      tick();
    end
  endtask

  initial begin
    int fs0, fs1, len, n;
    model_reset();
    fd_count = 0; fs_count = 0; fd_cycle = 0; pwm_or = '0;

    // Reset and quiet idle.
    #2 RESET = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
    check_eq("rst_pwm", 32'(PWM), 0);
    check_eq("rst_active_ch", 32'(active_ch), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_frame_start", 32'(frame_start), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    repeat (10) tick();
    check_eq("idle_busy", 32'(busy), 0);

    // Full frame: ontime {3,5,2,4}, gap 2, all channels.
    cfg_write(0, 3); cfg_write(1, 5); cfg_write(2, 2); cfg_write(3, 4); cfg_write(4, 2);
    SW3t0 = 4'hF;
    repeat (3) tick();
    SW17 = 1'b1;
    tick(); check_eq("start_fs_e1", 32'(frame_start), 0);
    tick(); check_eq("start_fs_e2", 32'(frame_start), 0);
    tick(); check_eq("start_fs_e3", 32'(frame_start), 1);
    check_eq("start_pwm_e3", 32'(PWM), 0);
    fs0 = cycle;
    tick(); check_eq("start_pwm_e4", 32'(PWM), 1);
    fd_count = 0;
    wait_fs(fs1);
    check_eq("frame_len", fs1 - fs0, 23);
    check_eq("frame_done_count", fd_count, 1);
    check_eq("done_to_start", fs1 - fd_cycle, 1);

    // Mid-frame on-time write lands in the following frame.
    wait_pwm(0);
    cfg_write(1, 9);
    measure_pulse(1, len);
    check_eq("ch1_len_cur", len, 5);
    measure_pulse(1, len);
    check_eq("ch1_len_next", len, 9);

    // Run switch dropped during a pulse.
    wait_pwm(1);
    SW17 = 1'b0;
    fd_count = 0; pwm_or = '0;
    repeat (40) tick();
    check_eq("drop_no_done", fd_count, 0);
    check_eq("drop_no_later_ch", 32'(pwm_or & 4'b1100), 0);
    check_eq("drop_idle", 32'(busy), 0);

    // Masked and zero-on-time channels are skipped.
    cfg_write(3, 0);
    SW3t0 = 4'b1010;
    SW17 = 1'b1;
    pwm_or = '0;
    repeat (40) tick();
    check_eq("skip_only_ch1", 32'(pwm_or), 32'(4'b0010));
    SW17 = 1'b0;
    repeat (40) tick();

    // Empty mask: LOAD falls straight back to IDLE.
    SW3t0 = '0;
    SW17 = 1'b1;
    pwm_or = '0; fs_count = 0;
    repeat (12) tick();
    check_eq("mask0_no_pwm", 32'(pwm_or), 0);
    check_eq("mask0_loads", 32'(fs_count > 0), 1);
    SW17 = 1'b0;
    repeat (5) tick();
    check_eq("mask0_idle", 32'(busy), 0);

    // Zero gap still gives one dead cycle per channel.
    cfg_write(4, 0); cfg_write(0, 2); cfg_write(1, 1); cfg_write(2, 3); cfg_write(3, 1);
    SW3t0 = 4'hF;
    SW17 = 1'b1;
    wait_fs(fs0);
    wait_fs(fs1);
    check_eq("gap0_frame_len", fs1 - fs0, 12);
    SW17 = 1'b0;
    repeat (30) tick();

    // Randomized configuration, switch activity and mid-frame writes.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i <= NCH; i++) cfg_write(i, $urandom_range(0, 5));
      SW3t0 = NCH'($urandom);
      SW17  = 1'b1;
      n = $urandom_range(40, 150);
      for (int c = 0; c < n; c++) begin
        cfg_we = ($urandom_range(0, 7) == 0);
        cfg_addr = AW'($urandom_range(0, NCH));
        cfg_data = TW'($urandom_range(0, 5));
        if ($urandom_range(0, 15) == 0) SW3t0 = NCH'($urandom);
        if ($urandom_range(0, 31) == 0) SW17 = ~SW17;
        tick();
      end
      cfg_we = 1'b0;
      SW17 = 1'b0;
      repeat (40) tick();
      check_eq("rand_idle", 32'(busy), 0);
    end

    // Asynchronous reset in the middle of a pulse.
    cfg_write(0, 6); cfg_write(1, 6); cfg_write(4, 2);
    SW3t0 = 4'b0011;
    SW17 = 1'b1;
    wait_pwm(0);
    #2 RESET = 1'b0;
    #1;
    check_eq("async_rst_pwm", 32'(PWM), 0);
    check_eq("async_rst_busy", 32'(busy), 0);
    model_reset();
    repeat (3) tick();
    SW17 = 1'b0;
    RESET = 1'b1;
    repeat (5) tick();
    check_eq("post_rst_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
